color_conv_ctrl: RTL
====================

# color_conv_ctrl

Job controller for the colour converter's combinational RGB-to-YCbCr core. It accepts a pixel-count job, streams RGB beats from the input stream through the core, and buffers results in a 2-entry output FIFO with valid/ready handshakes on both sides. It signals completion with a one-cycle done pulse. It sits between the HWPE streamer and the converter core, so the core never sees a pixel that cannot be stored.

## Interface
- CNT_W, default 16: width of the job length and the pixel counter.
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- start_i  in  1  job start, sampled in IDLE only.
- clear_i  in  1  synchronous abort.
- len_i  in  CNT_W  pixels in the job, sampled with start_i.
- busy_o  out  1  high in any state other than IDLE.
- done_o  out  1  one-cycle pulse at job completion.
- pix_cnt_o  out  CNT_W  pixels emitted on the output stream in the current job.
- in_valid_i / in_ready_o  in/out  1  RGB input handshake.
- in_data_i  in  24  pixel: R in [23:16], G in [15:8], B in [7:0].
- conv_rgb_o  out  24  drive to the core input, same packing as in_data_i.
- conv_ycbcr_i  in  24  core result: Y in [23:16], Cb in [15:8], Cr in [7:0].
- out_valid_o / out_ready_i  out/in  1  YCbCr output handshake.
- out_data_o  out  24  FIFO head.
- out_last_o  out  1  high with the final beat of the job.

## Operation
- The FSM has four states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start_i with len_i != 0 latches len_i, zeroes both counters and moves to RUN.
  - start_i with len_i == 0 moves to DONE directly.
- RUN:
  - in_ready_o = (FIFO occupancy + in-flight beats) < 2.
  - A beat is accepted when in_valid_i && in_ready_o; acc_cnt increments on each accepted beat.
  - When acc_cnt reaches len, the FSM moves to DRAIN and in_ready_o drops.
- DRAIN: waits until the FIFO is empty and nothing is in flight, then moves to DONE.
- DONE: done_o is high for exactly one cycle, then the FSM returns to IDLE.
- in_ready_o is 0 outside RUN.
- start_i is ignored while busy_o is high.
- Without the macro, conv_rgb_o = in_data_i combinationally, and conv_ycbcr_i is written to the FIFO tail in the acceptance cycle.
- FIFO:
  - Two entries, with read and write pointers plus an occupancy count.
  - Simultaneous push and pop at full or empty is legal; occupancy is unchanged.
  - out_valid_o = occupancy != 0.
  - out_data_o is held stable while out_valid_o && !out_ready_i.
- pix_cnt_o increments on each output handshake.
- out_last_o = out_valid_o && (pix_cnt_o == len-1).
- Counters are CNT_W bits wide and never wrap, because len ≤ 2^CNT_W-1.
- clear_i has priority over every other input. In the next cycle:
  - the FSM is in IDLE;
  - the FIFO and the in-flight register are flushed;
  - both counters are 0;
  - done_o is not pulsed.
- An output handshake in the same cycle as clear_i is discarded.

## Timing
- Reset values:
  - FSM in IDLE.
  - busy_o, done_o, in_ready_o, out_valid_o and out_last_o are 0.
  - pix_cnt_o = 0.
  - out_data_o = 0.
  - conv_rgb_o = 0 when the macro is defined; otherwise it follows in_data_i.
- Latency from input acceptance to out_valid_o is 1 cycle without the macro.
- Sustained throughput is 1 pixel/cycle when out_ready_i is held high.
- done_o asserts 1 cycle after the cycle in which the final output handshake leaves the pipeline empty.
- busy_o falls in the same cycle done_o falls.
- start_i in the cycle done_o is high is ignored; start is accepted from the following cycle.
- For a len_i == 0 job, done_o is high in the cycle after start_i.

## Configuration
- COLOR_CONV_CTRL_INREG_EN inserts a register between in_data_i and conv_rgb_o, plus an in-flight valid bit.
- Defined:
  - The core input is registered.
  - Results are written to the FIFO one cycle after acceptance, so latency is 2 cycles.
  - The in-flight beat counts toward in_ready_o, and throughput stays 1 pixel/cycle.
- Undefined: the path is combinational, latency is 1 cycle, and the in-flight count is always 0.

## Test plan
- Black pixel, single beat: len=1, in_data_i=0x000000 with the real core → out_data_o=0x008080, out_last_o=1, then done_o pulses once and pix_cnt_o=1.
- Back-to-back streaming: len=8, in_valid_i held high, out_ready_i held high → 8 beats at 1/cycle, out_last_o only on the 8th beat, done_o 1 cycle after that beat.
- Backpressure: len=4, out_ready_i=0 for 5 cycles → exactly 2 beats accepted, then in_ready_o=0, out_data_o stable; on release all 4 results arrive in order with none lost.
- Zero-length job: start_i with len_i=0 → done_o high in the next cycle, no output beats; a second start_i in the done_o cycle is ignored.
- Abort and reset: clear_i asserted after 3 of 10 beats → IDLE next cycle, out_valid_o=0, pix_cnt_o=0, no done_o. Asserting rst_ni low mid-RUN gives the same outputs asynchronously.
- With the macro defined, rerun the streaming and backpressure scenarios → latency 2 cycles, same ordering, and occupancy + in-flight never exceeds 2.

Source files
------------

// File: rtl/color_conv_ctrl.sv
// Job controller feeding the RGB-to-YCbCr core and buffering results in a 2-entry FIFO.
// Optional COLOR_CONV_CTRL_INREG_EN registers the core input and adds an in-flight stage.
module color_conv_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             clear_i,
    input  logic [CNT_W-1:0] len_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] pix_cnt_o,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [23:0]      in_data_i,
    output logic [23:0]      conv_rgb_o,
    input  logic [23:0]      conv_ycbcr_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [23:0]      out_data_o,
    output logic             out_last_o,
    output logic [1:0]       dbg_state_o
);

    // Both stream ports: a beat transfers on a rising edge where valid && ready;
    // valid never waits for ready, and out_data_o is held while valid && !ready.

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [CNT_W-1:0] r_len;
    logic [CNT_W-1:0] r_acc_cnt;
    logic [CNT_W-1:0] r_pix_cnt;

    logic [23:0]      r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_occ;

    logic             w_inflight;
    logic             w_push;
    logic             w_pop;
    logic             w_accept;
    logic             w_start;
    logic             w_acc_last;
    logic             w_drain_empty;
    logic [1:0]       w_load;
    logic             w_run;

    assign w_run    = (r_state == S_RUN);
    assign w_load   = r_occ + {1'b0, w_inflight};
    assign w_accept = in_valid_i && in_ready_o;
    assign w_pop    = out_valid_o && out_ready_i && !clear_i;
    assign w_start  = (r_state == S_IDLE) && start_i && !clear_i;

`ifdef COLOR_CONV_CTRL_INREG_EN
    logic        r_inflight;
    logic [23:0] r_rgb;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_inflight <= 1'b0;
            r_rgb      <= 24'd0;
        end else if (clear_i) begin
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_accept;
            if (w_accept) begin
                r_rgb <= in_data_i;
            end
        end
    end

    assign w_inflight = r_inflight;
    assign conv_rgb_o = r_rgb;
    assign w_push     = r_inflight;
    // A pop this cycle frees a slot, which keeps 1 pixel/cycle with the extra stage.
    assign in_ready_o = w_run && ((w_load < 2'd2) || ((w_load == 2'd2) && w_pop));
`else
    assign w_inflight = 1'b0;
    assign conv_rgb_o = in_data_i;
    assign w_push     = w_accept;
    assign in_ready_o = w_run && (w_load < 2'd2);
`endif

    assign w_acc_last    = w_accept && ((r_acc_cnt + CNT_W'(1)) == r_len);
    // Look ahead by the current pop so done follows the final handshake by one cycle.
    assign w_drain_empty = !w_inflight && ((r_occ == 2'd0) || ((r_occ == 2'd1) && w_pop));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    if (len_i != '0) begin
                        w_state_nxt = S_RUN;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_RUN: begin
                if (w_acc_last) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_drain_empty) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (clear_i) begin
            w_state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_len     <= '0;
            r_acc_cnt <= '0;
            r_pix_cnt <= '0;
        end else if (clear_i) begin
            r_acc_cnt <= '0;
            r_pix_cnt <= '0;
        end else if (w_start) begin
            r_len     <= len_i;
            r_acc_cnt <= '0;
            r_pix_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_acc_cnt <= r_acc_cnt + CNT_W'(1);
            end
            if (w_pop) begin
                r_pix_cnt <= r_pix_cnt + CNT_W'(1);
            end
        end
    end

    // Push at full only ever coincides with a pop, which frees the slot being written.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_mem[0] <= 24'd0;
            r_mem[1] <= 24'd0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_occ    <= 2'd0;
        end else if (clear_i) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_occ    <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= conv_ycbcr_i;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign busy_o      = (r_state != S_IDLE);
    assign done_o      = (r_state == S_DONE);
    assign dbg_state_o = r_state;
    assign pix_cnt_o   = r_pix_cnt;
    assign out_valid_o = (r_occ != 2'd0);
    assign out_data_o  = r_mem[r_rd_ptr];
    assign out_last_o  = out_valid_o && (r_pix_cnt == (r_len - CNT_W'(1)));

endmodule
